// File: rtl/potential_decay_array.sv
// Time-multiplexed membrane-potential decay engine: one datapath sweeps a register file of NUM_NEURONS potentials.
// Optional spike/reset-on-threshold output is enabled by defining POTENTIAL_DECAY_SPIKE_EN.
module potential_decay_array #(
    parameter int NUM_NEURONS = 16,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 16,
    parameter int LEAK        = 1
`ifdef POTENTIAL_DECAY_SPIKE_EN
    ,
    parameter int THRESHOLD   = 64
`endif
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [1:0]               model,
    input  logic [3:0]               decay_rate,
    input  logic                     init_en,
    input  logic [ADDR_W-1:0]        init_addr,
    input  logic signed [DATA_W-1:0] init_potential,
    input  logic                     acc_en,
    input  logic [ADDR_W-1:0]        acc_addr,
    input  logic signed [DATA_W-1:0] acc_weight,
    output logic                     busy,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_addr,
    output logic signed [DATA_W-1:0] out_potential,
    output logic                     done,
    output logic                     overrun
`ifdef POTENTIAL_DECAY_SPIKE_EN
    ,
    output logic                     spike
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic signed [DATA_W-1:0] LEAK_S  = DATA_W'(LEAK);
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef POTENTIAL_DECAY_SPIKE_EN
    localparam logic signed [DATA_W-1:0] THRESH_S = DATA_W'(THRESHOLD);
`endif

    function automatic logic signed [DATA_W-1:0] decay_fn(
        input logic signed [DATA_W-1:0] v,
        input logic [1:0]               m,
        input logic [3:0]               r
    );
        logic signed [DATA_W-1:0] res;
        case (m)
            2'b00: res = v - (v >>> r);
            2'b10: begin
                if (v > LEAK_S)       res = v - LEAK_S;
                else if (v < -LEAK_S) res = v + LEAK_S;
                else                  res = '0;
            end
            default: res = v;
        endcase
        return res;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        // Overflow shows as disagreement between the carry-out and the sign bit.
        if (s[DATA_W] != s[DATA_W-1]) return s[DATA_W] ? SAT_MIN : SAT_MAX;
        return s[DATA_W-1:0];
    endfunction

    logic [1:0]               state_q, state_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic                     clear_q;
    logic                     start, sweep, last;
    logic signed [DATA_W-1:0] mem_q [NUM_NEURONS];
    logic signed [DATA_W-1:0] mem_d [NUM_NEURONS];
    logic signed [DATA_W-1:0] cur_v, dec_v, wb_v;
    logic                     busy_q, out_valid_q, done_q, overrun_q;
    logic [ADDR_W-1:0]        out_addr_q;
    logic signed [DATA_W-1:0] out_pot_q;
`ifdef POTENTIAL_DECAY_SPIKE_EN
    logic                     spk, spike_q;
`endif

    assign start = clear & ~clear_q;
    assign sweep = (state_q == S_SWEEP);
    assign last  = (int'(idx_q) == NUM_NEURONS - 1);

    always_comb begin
        cur_v = mem_q[idx_q];
        dec_v = decay_fn(cur_v, model, decay_rate);
`ifdef POTENTIAL_DECAY_SPIKE_EN
        spk  = (dec_v >= THRESH_S);
        wb_v = spk ? '0 : dec_v;
`else
        wb_v = dec_v;
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SWEEP;
                    idx_d   = '0;
                end
            end
            S_SWEEP: begin
                if (last) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Write priority: sweep writeback, then accumulate on top of it, then init overrides both.
    always_comb begin
        mem_d = mem_q;
        if (sweep) mem_d[idx_q] = wb_v;
        if (acc_en && (int'(acc_addr) < NUM_NEURONS))
            mem_d[acc_addr] = sat_add(mem_d[acc_addr], acc_weight);
        if (init_en && (int'(init_addr) < NUM_NEURONS))
            mem_d[init_addr] = init_potential;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            clear_q     <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_pot_q   <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef POTENTIAL_DECAY_SPIKE_EN
            spike_q     <= 1'b0;
`endif
            for (int i = 0; i < NUM_NEURONS; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            clear_q     <= clear;
            mem_q       <= mem_d;
            busy_q      <= (state_d == S_SWEEP);
            out_valid_q <= sweep;
            done_q      <= sweep && last;
            if (sweep) begin
                out_addr_q <= idx_q;
                out_pot_q  <= dec_v;
            end
            if (start && (state_q != S_IDLE)) overrun_q <= 1'b1;
`ifdef POTENTIAL_DECAY_SPIKE_EN
            spike_q     <= sweep && spk;
`endif
        end
    end

    assign busy          = busy_q;
    assign out_valid     = out_valid_q;
    assign out_addr      = out_addr_q;
    assign out_potential = out_pot_q;
    assign done          = done_q;
    assign overrun       = overrun_q;
`ifdef POTENTIAL_DECAY_SPIKE_EN
    assign spike         = spike_q;
`endif

endmodule
